// File: rtl/queue_ptr_counter_if.sv
// Request/status bundle between a queue client and the pointer/occupancy counter.
interface queue_ptr_counter_if #(
  parameter int unsigned NUM_OF_BIT = 4
);

  // Requests from the client
  logic                  enable;
  logic                  clear;
  logic                  push;
  logic                  pop;

  // Addresses and status returned by the counter
  logic [NUM_OF_BIT-1:0] wr_ptr;
  logic [NUM_OF_BIT-1:0] rd_ptr;
  logic [NUM_OF_BIT:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  push_ack;
  logic                  pop_ack;
  logic                  overflow;
  logic                  underflow;

  // Client side: issues requests, observes status
  modport master (
    output enable, clear, push, pop,
    input  wr_ptr, rd_ptr, count, full, empty, almost_full, almost_empty,
           push_ack, pop_ack, overflow, underflow
  );

  // Counter side: consumes requests, drives status
  modport slave (
    input  enable, clear, push, pop,
    output wr_ptr, rd_ptr, count, full, empty, almost_full, almost_empty,
           push_ack, pop_ack, overflow, underflow
  );

endinterface

// File: rtl/queue_ptr_counter.sv
// Write/read index counters with arbitrary-depth wrap, occupancy count,
// threshold flags and sticky overflow/underflow for circular-buffer queues.
// Every output comes straight from a register; flags are derived from the
// next-state count so they always agree with the count they accompany.
module queue_ptr_counter #(
  parameter int unsigned NUM_OF_BIT = 4,
  parameter int unsigned DEPTH      = 11,
  parameter int unsigned AF_TH      = DEPTH - 2,
  parameter int unsigned AE_TH      = 2
) (
  input  logic                clk,
  input  logic                reset,
  queue_ptr_counter_if.slave  bus
);

  localparam int unsigned PW = NUM_OF_BIT;
  localparam int unsigned CW = NUM_OF_BIT + 1;

  typedef struct packed {
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          push_ack;
    logic          pop_ack;
    logic          overflow;
    logic          underflow;
  } state_t;

  state_t cur;
  state_t nxt;
  logic   push_ok;
  logic   pop_ok;

  // Idle state shared by reset and clear: empty queue, no acks, no errors
  function automatic state_t idle_state();
    state_t s;
    s              = '0;
    s.empty        = 1'b1;
    s.almost_empty = 1'b1;
    return s;
  endfunction

  // Index advance with wrap at DEPTH-1 (depth need not be a power of two)
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state: hold when disabled, flush on clear, otherwise push/pop update
  always_comb begin
    nxt     = cur;
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    if (bus.enable) begin
      if (bus.clear) begin
        nxt = idle_state();
      end else begin
        // A pop frees a slot in the same edge, so push-while-full is legal with pop
        pop_ok  = bus.pop & ~cur.empty;
        push_ok = bus.push & (~cur.full | pop_ok);

        if (push_ok) nxt.wr_ptr = advance(cur.wr_ptr);
        if (pop_ok)  nxt.rd_ptr = advance(cur.rd_ptr);

        unique case ({push_ok, pop_ok})
          2'b10:   nxt.count = cur.count + CW'(1);
          2'b01:   nxt.count = cur.count - CW'(1);
          default: nxt.count = cur.count;
        endcase

        nxt.push_ack  = push_ok;
        nxt.pop_ack   = pop_ok;
        nxt.overflow  = cur.overflow  | (bus.push & ~push_ok);
        nxt.underflow = cur.underflow | (bus.pop  & ~pop_ok);

        nxt.full         = (nxt.count == CW'(DEPTH));
        nxt.empty        = (nxt.count == '0);
        nxt.almost_full  = (nxt.count >= CW'(AF_TH));
        nxt.almost_empty = (nxt.count <= CW'(AE_TH));
      end
    end
  end

  // State register; reset overrides enable, clear and requests
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= idle_state();
    end else begin
      cur <= nxt;
    end
  end

  assign bus.wr_ptr       = cur.wr_ptr;
  assign bus.rd_ptr       = cur.rd_ptr;
  assign bus.count        = cur.count;
  assign bus.full         = cur.full;
  assign bus.empty        = cur.empty;
  assign bus.almost_full  = cur.almost_full;
  assign bus.almost_empty = cur.almost_empty;
  assign bus.push_ack     = cur.push_ack;
  assign bus.pop_ack      = cur.pop_ack;
  assign bus.overflow     = cur.overflow;
  assign bus.underflow    = cur.underflow;

endmodule

// File: tb/tb_queue_ptr_counter.sv
// Directed vector table for the queue scenarios plus a randomized run
// checked against an arithmetic model of the queue occupancy rules.
module tb_queue_ptr_counter;

  localparam int NB    = 4;
  localparam int DEPTH = 11;
  localparam int AF_TH = DEPTH - 2;
  localparam int AE_TH = 2;

  logic clk;
  logic reset;
  queue_ptr_counter_if #(.NUM_OF_BIT(NB)) bus ();

  queue_ptr_counter #(
    .NUM_OF_BIT(NB),
    .DEPTH     (DEPTH),
    .AF_TH     (AF_TH),
    .AE_TH     (AE_TH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, clr, psh, pop;
    int   cnt, wr, rd;
    logic pk, pp, ov, ud;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int m_cnt, m_wr, m_rd;
  bit m_pk, m_pp, m_ov, m_ud;

  task automatic add(input logic rst, en, clr, psh, pop,
                     input int cnt, wr, rd,
                     input logic pk, pp, ov, ud);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.psh = psh; v.pop = pop;
    v.cnt = cnt; v.wr = wr; v.rd = rd;
    v.pk = pk; v.pp = pp; v.ov = ov; v.ud = ud;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drive at falling edge, let one rising edge pass, settle before sampling
  task automatic drive(input logic r, e, c, p, q);
    @(negedge clk);
    reset = r; bus.enable = e; bus.clear = c; bus.push = p; bus.pop = q;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_flags(input int cnt, input bit pk, pp, ov, ud);
    return int'({cnt == DEPTH, cnt == 0, cnt >= AF_TH, cnt <= AE_TH, pk, pp, ov, ud});
  endfunction

  function automatic int act_flags();
    return int'({bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                 bus.push_ack, bus.pop_ack, bus.overflow, bus.underflow});
  endfunction

  task automatic check_all(input string tag, input int idx, input int cnt, wr, rd,
                           input bit pk, pp, ov, ud);
    check({tag, ".count"},  idx, int'(bus.count),  cnt);
    check({tag, ".wr_ptr"}, idx, int'(bus.wr_ptr), wr);
    check({tag, ".rd_ptr"}, idx, int'(bus.rd_ptr), rd);
    check({tag, ".flags"},  idx, act_flags(), exp_flags(cnt, pk, pp, ov, ud));
  endtask

  // Queue rules at transaction level: occupancy bounded to 0..DEPTH, indices mod DEPTH
  task automatic model_step(input bit r, e, c, p, q);
    bit pop_ok, push_ok;
    if (r || (e && c)) begin
      m_cnt = 0; m_wr = 0; m_rd = 0;
      m_pk = 0; m_pp = 0; m_ov = 0; m_ud = 0;
    end else if (e) begin
      pop_ok  = q && (m_cnt > 0);
      push_ok = p && ((m_cnt < DEPTH) || pop_ok);
      if (push_ok) begin m_cnt++; m_wr = (m_wr + 1) % DEPTH; end
      if (pop_ok)  begin m_cnt--; m_rd = (m_rd + 1) % DEPTH; end
      m_pk = push_ok;
      m_pp = pop_ok;
      if (p && !push_ok) m_ov = 1;
      if (q && !pop_ok)  m_ud = 1;
    end
  endtask

  initial begin
    reset = 1'b1; bus.enable = 1'b0; bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;

    // Reset state
    add(1,1,0,0,0, 0,0,0, 0,0,0,0);
    // Fill to full; write index wraps back to 0 on the 11th push
    for (int i = 1; i <= DEPTH; i++) add(0,1,0,1,0, i, i % DEPTH, 0, 1,0,0,0);
    // Push while full is rejected
    add(0,1,0,1,0, 11,0,0, 0,0,1,0);
    // Push+pop at full: both accepted, count unchanged
    add(0,1,0,1,1, 11,1,1, 1,1,1,0);
    // Drain to empty; read index wraps through 10 -> 0
    for (int i = 1; i <= DEPTH; i++) add(0,1,0,0,1, DEPTH - i, 1, (1 + i) % DEPTH, 0,1,1,0);
    // Pop while empty is rejected
    add(0,1,0,0,1, 0,1,1, 0,0,1,1);
    // Push+pop at empty: push wins, pop rejected
    add(0,1,0,1,1, 1,2,1, 1,0,1,1);
    // Clear with push: flush, push ignored
    add(0,1,1,1,0, 0,0,0, 0,0,0,0);
    for (int i = 1; i <= 5; i++) add(0,1,0,1,0, i, i, 0, 1,0,0,0);
    // Enable low: everything holds, including the ack and errors
    for (int i = 0; i < 20; i++) add(0,0,(i % 4) == 0,1,(i % 3) == 0, 5,5,0, 1,0,0,0);
    add(0,1,0,1,0, 6,6,0, 1,0,0,0);
    for (int i = 7; i <= DEPTH; i++) add(0,1,0,1,0, i, i % DEPTH, 0, 1,0,0,0);
    add(0,1,0,1,0, 11,0,0, 0,0,1,0);
    for (int i = 1; i <= 6; i++) add(0,1,0,0,1, DEPTH - i, 0, i, 0,1,1,0);
    // Clear at count 5 with overflow set
    add(0,1,1,1,0, 0,0,0, 0,0,0,0);
    for (int i = 1; i <= 3; i++) add(0,1,0,1,0, i, i, 0, 1,0,0,0);
    // Reset mid-count overrides disabled/clear/push/pop
    add(1,0,1,1,1, 0,0,0, 0,0,0,0);
    add(0,1,0,1,0, 1,1,0, 1,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].psh, vecs[i].pop);
      check_all("vec", i, vecs[i].cnt, vecs[i].wr, vecs[i].rd,
                vecs[i].pk, vecs[i].pp, vecs[i].ov, vecs[i].ud);
    end

    // Randomized run with alternating fill-biased and drain-biased phases
    drive(1,0,0,0,0);
    model_step(1,0,0,0,0);
    check_all("rnd_rst", 0, m_cnt, m_wr, m_rd, m_pk, m_pp, m_ov, m_ud);
    for (int n = 0; n < 3000; n++) begin
      bit r, e, c, p, q;
      bit fill;
      fill = ((n / 150) % 2) == 0;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 99) == 0);
      p = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      q = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(r, e, c, p, q);
      model_step(r, e, c, p, q);
      check_all("rnd", n + 1, m_cnt, m_wr, m_rd, m_pk, m_pp, m_ov, m_ud);
      check("rnd.ptr_gap", n + 1,
            (int'(bus.wr_ptr) - int'(bus.rd_ptr) + DEPTH) % DEPTH,
            int'(bus.count) % DEPTH);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
